// File: rtl/bp_me_pkg.sv
// Shared types for the cache-DMA to BedRock memory adapter: configuration constants,
// BedRock memory message layout, bsg_cache DMA packet and adapter FSM states.
package bp_me_pkg;

  localparam int unsigned paddr_width_p     = 40;
  localparam int unsigned caddr_width_p     = 32;
  localparam int unsigned cce_block_width_p = 512;
  localparam int unsigned lce_id_width_p    = 4;
  localparam int unsigned lce_assoc_p       = 8;
  localparam int unsigned dword_width_gp    = 64;

  localparam int unsigned block_beats_lp    = cce_block_width_p / dword_width_gp;
  localparam int unsigned beat_cnt_width_lp = $clog2(block_beats_lp);
  localparam int unsigned dma_pkt_width_lp  = caddr_width_p + 1;
  localparam int unsigned block_offset_lp   = $clog2(cce_block_width_p / 8);
  localparam int unsigned way_id_width_lp   = $clog2(lce_assoc_p);

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0]   lce_id;
    logic [way_id_width_lp-1:0]  way_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s     payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_p-1:0]    addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    bp_bedrock_mem_header_s       header;
  } bp_bedrock_mem_msg_s;

  localparam int unsigned cce_mem_msg_width_lp = $bits(bp_bedrock_mem_msg_s);
  localparam int unsigned mem_header_width_lp  = $bits(bp_bedrock_mem_header_s);

  typedef struct packed {
    logic                     write_not_read;
    logic [caddr_width_p-1:0] addr;
  } bsg_cache_dma_pkt_s;

  typedef enum logic [2:0] {
    StIdle,
    StRdCmd,
    StRdWait,
    StRdStream,
    StWrCollect,
    StWrCmd,
    StWrWait
  } bp_me_dma_state_e;

endpackage

// File: rtl/bp_me_cache_dma_to_bedrock_dff.sv
// Enable-gated register with asynchronous active-low clear.
module bp_me_cache_dma_to_bedrock_dff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bp_me_cache_dma_to_bedrock.sv
// bsg_cache DMA slave: converts fill/evict transactions into full-block BedRock memory
// commands, one transaction in flight, fill data returned one dword per beat.
module bp_me_cache_dma_to_bedrock
  import bp_me_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            reset_i,

  input  logic [dma_pkt_width_lp-1:0]     dma_pkt_i,
  input  logic                            dma_pkt_v_i,
  output logic                            dma_pkt_yumi_o,

  output logic [dword_width_gp-1:0]       dma_data_o,
  output logic                            dma_data_v_o,
  input  logic                            dma_data_ready_i,

  input  logic [dword_width_gp-1:0]       dma_data_i,
  input  logic                            dma_data_v_i,
  output logic                            dma_data_yumi_o,

  output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_and_i,

  input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o
);

  localparam logic [beat_cnt_width_lp-1:0] LastBeat = beat_cnt_width_lp'(block_beats_lp - 1);

  bsg_cache_dma_pkt_s     dma_pkt;
  bp_bedrock_mem_msg_s    mem_resp;
  bp_bedrock_mem_msg_s    mem_cmd;
  bp_bedrock_mem_header_s hdr_d, hdr_q;
  bp_me_dma_state_e       state_d, state_q;

  logic [beat_cnt_width_lp-1:0] cnt_d, cnt_q;
  logic                         live_q;
  logic [dword_width_gp-1:0]    buf_q [block_beats_lp];
  logic [cce_block_width_p-1:0] buf_flat;

  assign dma_pkt  = dma_pkt_i;
  assign mem_resp = mem_resp_i;

  // Keeps every handshake low in the first cycle after reset release.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (dma_pkt_yumi_o) begin
          state_d = dma_pkt.write_not_read ? StWrCollect : StRdCmd;
        end
      end
      StRdCmd:  if (mem_cmd_ready_and_i) state_d = StRdWait;
      StRdWait: begin
        if (mem_resp_yumi_o) begin
          state_d = StRdStream;
          cnt_d   = '0;
        end
      end
      StRdStream: begin
        if (dma_data_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StIdle;
        end
      end
      StWrCollect: begin
        if (dma_data_yumi_o) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StWrCmd;
        end
      end
      StWrCmd:  if (mem_cmd_ready_and_i) state_d = StWrWait;
      StWrWait: if (mem_resp_yumi_o) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Valid outputs depend on state only; yumis just echo the matching valid.
  always_comb begin
    dma_pkt_yumi_o  = 1'b0;
    dma_data_v_o    = 1'b0;
    dma_data_yumi_o = 1'b0;
    mem_cmd_v_o     = 1'b0;
    mem_resp_yumi_o = 1'b0;
    unique case (state_q)
      StIdle:             dma_pkt_yumi_o  = live_q & dma_pkt_v_i;
      StRdCmd, StWrCmd:   mem_cmd_v_o     = 1'b1;
      StRdWait, StWrWait: mem_resp_yumi_o = mem_resp_v_i;
      StRdStream:         dma_data_v_o    = 1'b1;
      StWrCollect:        dma_data_yumi_o = dma_data_v_i;
      default: ;
    endcase
  end

  always_comb begin
    hdr_d          = '0;
    hdr_d.msg_type = dma_pkt.write_not_read ? e_bedrock_mem_wr : e_bedrock_mem_rd;
    hdr_d.size     = e_bedrock_msg_size_64;
    hdr_d.addr     = {{(paddr_width_p - caddr_width_p){1'b0}},
                      dma_pkt.addr[caddr_width_p-1:block_offset_lp],
                      {block_offset_lp{1'b0}}};
  end

  bp_me_cache_dma_to_bedrock_dff #(
    .Width(mem_header_width_lp)
  ) u_hdr_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (dma_pkt_yumi_o),
    .data_i (hdr_d),
    .data_o (hdr_q)
  );

  always_ff @(posedge clk_i) begin
    if (mem_resp_yumi_o && (state_q == StRdWait)) begin
      for (int i = 0; i < block_beats_lp; i++) begin
        buf_q[i] <= mem_resp.data[i*dword_width_gp +: dword_width_gp];
      end
    end else if (dma_data_yumi_o) begin
      buf_q[cnt_q] <= dma_data_i;
    end
  end

  always_comb begin
    buf_flat = '0;
    for (int i = 0; i < block_beats_lp; i++) begin
      buf_flat[i*dword_width_gp +: dword_width_gp] = buf_q[i];
    end
  end

  always_comb begin
    mem_cmd        = '0;
    mem_cmd.header = hdr_q;
    mem_cmd.data   = (state_q == StWrCmd) ? buf_flat : '0;
  end

  assign mem_cmd_o  = mem_cmd;
  assign dma_data_o = buf_q[cnt_q];

  logic unused_inputs;
  assign unused_inputs = ^{mem_resp.header, dma_pkt.addr[block_offset_lp-1:0]};

  resp_type_matches_a: assert property (@(posedge clk_i) disable iff (!reset_i)
    mem_resp_yumi_o |-> (mem_resp.header.msg_type == hdr_q.msg_type));

endmodule

// File: tb/tb_bp_me_cache_dma_to_bedrock.sv
// Directed bench for bp_me_cache_dma_to_bedrock: table of fill/evict transactions plus
// hand sequences for back-to-back packets, mid-stream reset and early evict data.
module tb_bp_me_cache_dma_to_bedrock;
  import bp_me_pkg::*;

  logic                            clk_i;
  logic                            reset_i;
  logic [dma_pkt_width_lp-1:0]     dma_pkt_i;
  logic                            dma_pkt_v_i;
  logic                            dma_pkt_yumi_o;
  logic [dword_width_gp-1:0]       dma_data_o;
  logic                            dma_data_v_o;
  logic                            dma_data_ready_i;
  logic [dword_width_gp-1:0]       dma_data_i;
  logic                            dma_data_v_i;
  logic                            dma_data_yumi_o;
  logic [cce_mem_msg_width_lp-1:0] mem_cmd_o;
  logic                            mem_cmd_v_o;
  logic                            mem_cmd_ready_and_i;
  logic [cce_mem_msg_width_lp-1:0] mem_resp_i;
  logic                            mem_resp_v_i;
  logic                            mem_resp_yumi_o;

  bp_bedrock_mem_msg_s cmd;
  assign cmd = mem_cmd_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          wnr;
    logic [31:0] addr;
    logic [39:0] exp_addr;
    logic [63:0] base;
    logic [63:0] step;
    int          stall;
  } vec_t;

  vec_t vecs [6];

  bp_me_cache_dma_to_bedrock dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .dma_pkt_i          (dma_pkt_i),
    .dma_pkt_v_i        (dma_pkt_v_i),
    .dma_pkt_yumi_o     (dma_pkt_yumi_o),
    .dma_data_o         (dma_data_o),
    .dma_data_v_o       (dma_data_v_o),
    .dma_data_ready_i   (dma_data_ready_i),
    .dma_data_i         (dma_data_i),
    .dma_data_v_i       (dma_data_v_i),
    .dma_data_yumi_o    (dma_data_yumi_o),
    .mem_cmd_o          (mem_cmd_o),
    .mem_cmd_v_o        (mem_cmd_v_o),
    .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
    .mem_resp_i         (mem_resp_i),
    .mem_resp_v_i       (mem_resp_v_i),
    .mem_resp_yumi_o    (mem_resp_yumi_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  function automatic logic [63:0] word(input vec_t v, input int i);
    return v.base + v.step * 64'(i);
  endfunction

  task automatic wait_cmd(input string name);
    int n = 0;
    while (!mem_cmd_v_o && n < 20) begin
      tick();
      n++;
    end
    check({name, "_cmd_timeout"}, 64'(mem_cmd_v_o), 64'd1);
  endtask

  task automatic send_resp(input bp_bedrock_mem_type_e t, input vec_t v, input string name);
    bp_bedrock_mem_msg_s resp;
    resp                 = '0;
    resp.header.msg_type = t;
    for (int i = 0; i < 8; i++) resp.data[i*64 +: 64] = word(v, i);
    mem_resp_i   = resp;
    mem_resp_v_i = 1'b1;
    #1;
    check({name, "_resp_yumi"}, 64'(mem_resp_yumi_o), 64'd1);
    tick();
    mem_resp_v_i = 1'b0;
  endtask

  task automatic run_fill(input vec_t v, input bit pkt_sent, input string name);
    if (!pkt_sent) begin
      dma_pkt_i   = {1'b0, v.addr};
      dma_pkt_v_i = 1'b1;
      #1;
      check({name, "_pkt_yumi"}, 64'(dma_pkt_yumi_o), 64'd1);
      tick();
      dma_pkt_v_i = 1'b0;
    end
    wait_cmd(name);
    #1;
    check({name, "_rd_type"}, 64'(cmd.header.msg_type), 64'(e_bedrock_mem_rd));
    check({name, "_rd_addr"}, 64'(cmd.header.addr), 64'(v.exp_addr));
    check({name, "_rd_size"}, 64'(cmd.header.size), 64'(e_bedrock_msg_size_64));
    check({name, "_rd_data0"}, 64'(|cmd.data), 64'd0);
    repeat (v.stall) begin
      tick();
      #1;
      check({name, "_rd_stall_v"}, 64'(mem_cmd_v_o), 64'd1);
      check({name, "_rd_stall_addr"}, 64'(cmd.header.addr), 64'(v.exp_addr));
    end
    mem_cmd_ready_and_i = 1'b1;
    tick();
    mem_cmd_ready_and_i = 1'b0;
    #1;
    check({name, "_rd_cmd_drop"}, 64'(mem_cmd_v_o), 64'd0);
    send_resp(e_bedrock_mem_rd, v, name);
    for (int i = 0; i < 8; i++) begin
      if (v.stall != 0) begin
        dma_data_ready_i = 1'b0;
        #1;
        check($sformatf("%s_hold%0d", name, i), dma_data_o, word(v, i));
        tick();
      end
      dma_data_ready_i = 1'b1;
      #1;
      check($sformatf("%s_beat_v%0d", name, i), 64'(dma_data_v_o), 64'd1);
      check($sformatf("%s_beat%0d", name, i), dma_data_o, word(v, i));
      tick();
    end
    dma_data_ready_i = 1'b0;
    #1;
    check({name, "_fill_done"}, 64'(dma_data_v_o), 64'd0);
  endtask

  task automatic run_evict(input vec_t v, input bit pkt_sent, input bit hold, input string name);
    int gap;
    if (!pkt_sent) begin
      dma_pkt_i   = {1'b1, v.addr};
      dma_pkt_v_i = 1'b1;
      #1;
      check({name, "_pkt_yumi"}, 64'(dma_pkt_yumi_o), 64'd1);
      tick();
      dma_pkt_v_i = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        dma_data_v_i = 1'b0;
        tick();
      end
      dma_data_i   = word(v, i);
      dma_data_v_i = 1'b1;
      #1;
      check($sformatf("%s_ev_yumi%0d", name, i), 64'(dma_data_yumi_o), 64'd1);
      if (hold) check({name, "_b2b_hold"}, 64'(dma_pkt_yumi_o), 64'd0);
      tick();
    end
    dma_data_v_i = 1'b0;
    wait_cmd(name);
    #1;
    check({name, "_wr_type"}, 64'(cmd.header.msg_type), 64'(e_bedrock_mem_wr));
    check({name, "_wr_addr"}, 64'(cmd.header.addr), 64'(v.exp_addr));
    check({name, "_wr_size"}, 64'(cmd.header.size), 64'(e_bedrock_msg_size_64));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_wr_data%0d", name, i), cmd.data[i*64 +: 64], word(v, i));
    end
    repeat (v.stall) begin
      tick();
      #1;
      check({name, "_wr_stall_d0"}, cmd.data[63:0], word(v, 0));
      check({name, "_wr_stall_d7"}, cmd.data[511:448], word(v, 7));
      check({name, "_wr_stall_v"}, 64'(mem_cmd_v_o), 64'd1);
    end
    if (hold) check({name, "_b2b_hold_cmd"}, 64'(dma_pkt_yumi_o), 64'd0);
    mem_cmd_ready_and_i = 1'b1;
    tick();
    mem_cmd_ready_and_i = 1'b0;
    #1;
    if (hold) check({name, "_b2b_hold_wait"}, 64'(dma_pkt_yumi_o), 64'd0);
    send_resp(e_bedrock_mem_wr, v, name);
    #1;
    check({name, "_wr_done"}, 64'(mem_cmd_v_o), 64'd0);
  endtask

  vec_t b2b_fill;
  vec_t rst_fill;
  vec_t rst_refill;

  initial begin
    vecs[0] = '{0, 32'h8000_1234, 40'h00_8000_1200, 64'h11, 64'h11, 0};
    vecs[1] = '{1, 32'h8000_0040, 40'h00_8000_0040, 64'hA0, 64'h1, 0};
    vecs[2] = '{0, 32'h0000_003F, 40'h00_0000_0000, 64'hDEAD_0000_0000_0000, 64'h1, 0};
    vecs[3] = '{1, 32'hFFFF_FFFF, 40'h00_FFFF_FFC0, 64'h0123_4567_89AB_CDEF, 64'h1111, 0};
    vecs[4] = '{0, 32'hFFFF_FFC0, 40'h00_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1, 5};
    vecs[5] = '{1, 32'h1234_5678, 40'h00_1234_5640, 64'h5555_0000, 64'h3, 5};
    b2b_fill   = '{0, 32'h4000_0100, 40'h00_4000_0100, 64'h7000, 64'h7, 0};
    rst_fill   = '{0, 32'h1000_0080, 40'h00_1000_0080, 64'h100, 64'h1, 0};
    rst_refill = '{0, 32'h1000_0080, 40'h00_1000_0080, 64'h200, 64'h2, 0};

    reset_i             = 1'b1;
    dma_pkt_i           = '0;
    dma_pkt_v_i         = 1'b1;
    dma_data_ready_i    = 1'b1;
    dma_data_i          = '0;
    dma_data_v_i        = 1'b1;
    mem_cmd_ready_and_i = 1'b0;
    mem_resp_i          = '0;
    mem_resp_v_i        = 1'b1;
    #1;
    reset_i = 1'b0;
    #1;
    check("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
    check("rst_data_yumi", 64'(dma_data_yumi_o), 64'd0);
    check("rst_resp_yumi", 64'(mem_resp_yumi_o), 64'd0);
    check("rst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    check("rst_data_v", 64'(dma_data_v_o), 64'd0);
    tick();
    tick();
    reset_i = 1'b1;
    #1;
    check("rel_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
    check("rel_resp_yumi", 64'(mem_resp_yumi_o), 64'd0);
    dma_pkt_v_i      = 1'b0;
    mem_resp_v_i     = 1'b0;
    dma_data_ready_i = 1'b0;
    tick();

    // Evict data while idle must not be consumed.
    for (int i = 0; i < 3; i++) begin
      dma_data_v_i = 1'b1;
      #1;
      check("early_evict_yumi", 64'(dma_data_yumi_o), 64'd0);
      tick();
    end
    dma_data_v_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wnr) run_evict(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
      else run_fill(vecs[i], 1'b0, $sformatf("vec%0d", i));
      tick();
    end

    // Evict immediately followed by a fill packet held valid.
    dma_pkt_i   = {1'b1, vecs[1].addr};
    dma_pkt_v_i = 1'b1;
    #1;
    check("b2b_first_yumi", 64'(dma_pkt_yumi_o), 64'd1);
    tick();
    dma_pkt_i = {1'b0, b2b_fill.addr};
    run_evict(vecs[1], 1'b1, 1'b1, "b2b_ev");
    check("b2b_second_yumi", 64'(dma_pkt_yumi_o), 64'd1);
    tick();
    dma_pkt_v_i = 1'b0;
    run_fill(b2b_fill, 1'b1, "b2b_fill");
    tick();

    // Reset in the middle of a fill stream after beat 3.
    dma_pkt_i   = {1'b0, rst_fill.addr};
    dma_pkt_v_i = 1'b1;
    #1;
    tick();
    dma_pkt_v_i = 1'b0;
    wait_cmd("rst_fill");
    mem_cmd_ready_and_i = 1'b1;
    tick();
    mem_cmd_ready_and_i = 1'b0;
    send_resp(e_bedrock_mem_rd, rst_fill, "rst_fill");
    for (int i = 0; i < 4; i++) begin
      dma_data_ready_i = 1'b1;
      #1;
      check($sformatf("rst_fill_beat%0d", i), dma_data_o, word(rst_fill, i));
      tick();
    end
    dma_pkt_v_i = 1'b1;
    reset_i     = 1'b0;
    #1;
    check("midrst_data_v", 64'(dma_data_v_o), 64'd0);
    check("midrst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    check("midrst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
    dma_data_ready_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    #1;
    check("midrst_rel_yumi", 64'(dma_pkt_yumi_o), 64'd0);
    check("midrst_rel_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    tick();
    check("midrst_new_yumi", 64'(dma_pkt_yumi_o), 64'd1);
    tick();
    dma_pkt_v_i = 1'b0;
    run_fill(rst_refill, 1'b1, "refill");
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
